// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the I/D unified-memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2,
      RESP   = 2'd3
   } state_e;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;

   localparam int DATA_W_DEF = 32;
   localparam int STRB_W     = DATA_W_DEF / 8;

   function automatic int strb_width(input int data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU-side (I and D requesters) and memory-side signals of the arbiter.
interface mem_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int SW = strb_width(DATA_W);

   logic              i_ireq;
   logic [ADDR_W-1:0] i_iaddr;
   logic [DATA_W-1:0] o_irdata;
   logic              o_iack;
   logic              i_dreq;
   logic [ADDR_W-1:0] i_daddr;
   logic              i_dwe;
   logic [DATA_W-1:0] i_dwdata;
   logic [SW-1:0]     i_dwstrb;
   logic [DATA_W-1:0] o_drdata;
   logic              o_dack;
   logic              o_err;
   logic              o_mem_req;
   logic [ADDR_W-1:0] o_mem_addr;
   logic              o_mem_we;
   logic [DATA_W-1:0] o_mem_wdata;
   logic [SW-1:0]     o_mem_wstrb;
   logic              i_mem_ack;
   logic [DATA_W-1:0] i_mem_rdata;

   modport slave (
      input  i_ireq, i_iaddr, i_dreq, i_daddr, i_dwe, i_dwdata, i_dwstrb,
      input  i_mem_ack, i_mem_rdata,
      output o_irdata, o_iack, o_drdata, o_dack, o_err,
      output o_mem_req, o_mem_addr, o_mem_we, o_mem_wdata, o_mem_wstrb
   );

   modport master (
      output i_ireq, i_iaddr, i_dreq, i_daddr, i_dwe, i_dwdata, i_dwstrb,
      output i_mem_ack, i_mem_rdata,
      input  o_irdata, o_iack, o_drdata, o_dack, o_err,
      input  o_mem_req, o_mem_addr, o_mem_we, o_mem_wdata, o_mem_wstrb
   );

endinterface

// File: rtl/mem_arb_timeout.sv
// Access watchdog: counts busy cycles and flags the last allowed one.
// TIMEOUT = 0 removes the counter and ties expired low.
module mem_arb_timeout #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   generate
      if (TIMEOUT == 0) begin : g_off
         assign expired = 1'b0;
      end else begin : g_on
         localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
         localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

         logic [CNT_W-1:0] count_r;

         // Busy-cycle counter, parked at LAST until cleared.
         always_ff @(posedge clk) begin
            if (rst || clear) begin
               count_r <= '0;
            end else if (enable && (count_r != LAST)) begin
               count_r <= count_r + CNT_W'(1);
            end else begin
               count_r <= count_r;
            end
         end

         assign expired = enable && (count_r == LAST);
      end
   endgenerate

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch (I) and load/store (D) onto one multi-cycle
// memory port. Define MEM_ARB_RR_EN for round-robin instead of D-over-I.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input logic          i_clock,
   input logic          i_reset,
   mem_arbiter_if.slave bus
);

   localparam int SW = strb_width(DATA_W);

   logic [1:0]        state_r;
   logic              mem_req_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic              mem_we_r;
   logic [DATA_W-1:0] mem_wdata_r;
   logic [SW-1:0]     mem_wstrb_r;
   logic [DATA_W-1:0] irdata_r;
   logic [DATA_W-1:0] drdata_r;
   logic              iack_r;
   logic              dack_r;
   logic              err_r;
   logic              busy_s;
   logic              expired_s;
   logic              any_req_s;
   owner_e            winner_s;

   assign busy_s    = (state_r == BUSY_I) || (state_r == BUSY_D);
   assign any_req_s = bus.i_ireq || bus.i_dreq;

   mem_arb_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (i_clock),
      .rst     (i_reset),
      .clear   (!busy_s),
      .enable  (busy_s),
      .expired (expired_s)
   );

`ifdef MEM_ARB_RR_EN
   owner_e last_grant_r;

   // Winner selection: on a tie, the requester not served last time.
   always_comb begin
      winner_s = OWN_I;
      if (bus.i_ireq && bus.i_dreq) begin
         winner_s = (last_grant_r == OWN_I) ? OWN_D : OWN_I;
      end else if (bus.i_dreq) begin
         winner_s = OWN_D;
      end else begin
         winner_s = OWN_I;
      end
   end

   // Most recent grant, updated whenever IDLE issues an access.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         last_grant_r <= OWN_I;
      end else if ((state_r == IDLE) && any_req_s) begin
         last_grant_r <= winner_s;
      end else begin
         last_grant_r <= last_grant_r;
      end
   end
`else
   // Winner selection: D always beats I.
   always_comb begin
      winner_s = OWN_I;
      if (bus.i_dreq) begin
         winner_s = OWN_D;
      end else begin
         winner_s = OWN_I;
      end
   end
`endif

   // Access FSM with registered memory request and requester responses.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_r     <= IDLE;
         mem_req_r   <= 1'b0;
         mem_addr_r  <= '0;
         mem_we_r    <= 1'b0;
         mem_wdata_r <= '0;
         mem_wstrb_r <= '0;
         irdata_r    <= '0;
         drdata_r    <= '0;
         iack_r      <= 1'b0;
         dack_r      <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (any_req_s) begin
                  mem_req_r <= 1'b1;
                  if (winner_s == OWN_D) begin
                     mem_addr_r  <= bus.i_daddr;
                     mem_we_r    <= bus.i_dwe;
                     mem_wdata_r <= bus.i_dwdata;
                     mem_wstrb_r <= bus.i_dwstrb;
                     state_r     <= BUSY_D;
                  end else begin
                     mem_addr_r  <= bus.i_iaddr;
                     mem_we_r    <= 1'b0;
                     mem_wdata_r <= '0;
                     mem_wstrb_r <= '0;
                     state_r     <= BUSY_I;
                  end
               end else begin
                  mem_req_r <= 1'b0;
               end
            end
            BUSY_I, BUSY_D: begin
               // An ack in the expiry cycle still counts as success.
               if (bus.i_mem_ack || expired_s) begin
                  mem_req_r <= 1'b0;
                  err_r     <= !bus.i_mem_ack;
                  state_r   <= RESP;
                  if (state_r == BUSY_I) begin
                     iack_r   <= 1'b1;
                     irdata_r <= bus.i_mem_ack ? bus.i_mem_rdata : '0;
                  end else begin
                     dack_r   <= 1'b1;
                     drdata_r <= (bus.i_mem_ack && !mem_we_r) ? bus.i_mem_rdata : '0;
                  end
               end else begin
                  mem_req_r <= 1'b1;
               end
            end
            RESP: begin
               iack_r  <= 1'b0;
               dack_r  <= 1'b0;
               err_r   <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               mem_req_r <= 1'b0;
               iack_r    <= 1'b0;
               dack_r    <= 1'b0;
               err_r     <= 1'b0;
               state_r   <= IDLE;
            end
         endcase
      end
   end

   assign bus.o_mem_req   = mem_req_r;
   assign bus.o_mem_addr  = mem_addr_r;
   assign bus.o_mem_we    = mem_we_r;
   assign bus.o_mem_wdata = mem_wdata_r;
   assign bus.o_mem_wstrb = mem_wstrb_r;
   assign bus.o_irdata    = irdata_r;
   assign bus.o_iack      = iack_r;
   assign bus.o_drdata    = drdata_r;
   assign bus.o_dack      = dack_r;
   assign bus.o_err       = err_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized + directed bench for mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;
   localparam int TO = 8;
`ifdef MEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .i_clock (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   // Model of the requesters and of the arbiter's visible state.
   bit            ip, dp, last_d;
   logic [AW-1:0] ia, da;
   logic          dwe;
   logic [DW-1:0] dwd;
   logic [SW-1:0] dws;
   logic [DW-1:0] exp_ird, exp_drd;
   int            checks = 0;
   int            failures = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive();
      bus.i_ireq   = ip;
      bus.i_iaddr  = ia;
      bus.i_dreq   = dp;
      bus.i_daddr  = da;
      bus.i_dwe    = dwe;
      bus.i_dwdata = dwd;
      bus.i_dwstrb = dws;
   endtask

   // Call in the IDLE cycle where requests are present (cycle 0).
   // k = cycle of the memory ack counted from cycle 0 (>=1); 0 = never.
   task automatic serve(input int k, input logic [DW-1:0] rd, input bit stray);
      bit            win_d, err;
      int            stop;
      logic [DW-1:0] exp_rd;
      win_d  = (ip && dp) ? (RR ? !last_d : 1'b1) : dp;
      last_d = win_d;
      err    = !(k >= 1 && k <= TO);
      stop   = err ? TO : k;
      chk("mem_req_idle", bus.o_mem_req, 1'b0);
      bus.i_mem_ack   = stray;
      bus.i_mem_rdata = rd;
      for (int c = 1; c <= stop; c++) begin
         tick();
         bus.i_mem_ack = (c == k);
         chk("mem_req_busy", bus.o_mem_req, 1'b1);
         chk("mem_addr", bus.o_mem_addr, win_d ? da : ia);
         chk("mem_we", bus.o_mem_we, win_d ? dwe : 1'b0);
         chk("mem_wstrb", bus.o_mem_wstrb, win_d ? dws : '0);
         if (win_d) chk("mem_wdata", bus.o_mem_wdata, dwd);
         chk("acks_busy", {bus.o_iack, bus.o_dack}, 2'b00);
      end
      tick();
      bus.i_mem_ack = $urandom_range(0, 1);
      exp_rd = (err || (win_d && dwe)) ? '0 : rd;
      if (win_d) exp_drd = exp_rd;
      else exp_ird = exp_rd;
      chk("mem_req_resp", bus.o_mem_req, 1'b0);
      chk("iack", bus.o_iack, !win_d);
      chk("dack", bus.o_dack, win_d);
      chk("err", bus.o_err, err);
      chk("irdata", bus.o_irdata, exp_ird);
      chk("drdata", bus.o_drdata, exp_drd);
      if (win_d) dp = 1'b0;
      else ip = 1'b0;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_req"}, bus.o_mem_req, 1'b0);
      chk({tag, "_acks"}, {bus.o_iack, bus.o_dack, bus.o_err}, 3'b000);
      chk({tag, "_mem"}, {bus.o_mem_addr, bus.o_mem_we, bus.o_mem_wstrb}, '0);
      chk({tag, "_rd"}, {bus.o_irdata, bus.o_drdata}, '0);
   endtask

   initial begin
      int k;
      ip = 0; dp = 0; last_d = 0; ia = '0; da = '0; dwe = 0; dwd = '0; dws = '0;
      exp_ird = '0; exp_drd = '0;
      drive();
      bus.i_mem_ack = 1'b0; bus.i_mem_rdata = '0;
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      chk_reset_state("reset");

      // Single I read, ack one cycle after the request appears.
      ip = 1; ia = 32'h0000_0010; drive();
      serve(2, 32'h0000_0093, 1'b0);

      // Simultaneous I and D read, immediate acks.
      ip = 1; ia = 32'h0000_0020; dp = 1; da = 32'h0000_0100; dwe = 0;
      drive(); tick(); serve(1, 32'h1111_2222, 1'b0);
      drive(); tick(); serve(1, 32'h3333_4444, 1'b0);

      // D write with delayed ack.
      dp = 1; da = 32'h0000_0200; dwe = 1; dwd = 32'hDEAD_BEEF; dws = 4'b0011;
      drive(); tick(); serve(4, 32'h5555_6666, 1'b0);

      // Timeout without ack, then ack landing in the last allowed cycle.
      dp = 1; da = 32'h0000_0300; dwe = 0;
      drive(); tick(); serve(0, 32'h7777_8888, 1'b0);
      dp = 1; da = 32'h0000_0304;
      drive(); tick(); serve(TO, 32'h9999_AAAA, 1'b0);

      // I held while D keeps re-requesting back to back.
      ip = 1; ia = 32'h0000_0400;
      for (int n = 0; n < 4; n++) begin
         dp = 1; da = 32'h0000_0500 + 32'(n * 4); dwe = 0;
         drive(); tick(); serve(1, $urandom, 1'b0);
      end

      // Random traffic.
      for (int n = 0; n < 40; n++) begin
         if (!ip && ($urandom_range(0, 1) == 1)) begin
            ip = 1; ia = $urandom;
         end
         if (!dp && (!ip || ($urandom_range(0, 1) == 1))) begin
            dp = 1; da = $urandom; dwe = $urandom_range(0, 1); dwd = $urandom; dws = SW'($urandom);
         end
         k = $urandom_range(0, 11);
         k = (k >= 10) ? 0 : k + 1;
         drive(); tick();
         serve(k, $urandom, $urandom_range(0, 1));
      end
      for (int n = 0; n < 2 && (ip || dp); n++) begin
         drive(); tick(); serve(1, $urandom, 1'b0);
      end

      // Reset in the middle of an I access, then a late ack.
      ip = 0; dp = 0; drive(); bus.i_mem_ack = 1'b0; tick();
      ip = 1; ia = 32'h0000_0600; drive(); tick();
      chk("rst_busy_req", bus.o_mem_req, 1'b1);
      rst = 1'b1; ip = 0; drive(); tick();
      rst = 1'b0; exp_ird = '0; exp_drd = '0; last_d = 0;
      chk_reset_state("midreset");
      bus.i_mem_ack = 1'b1; bus.i_mem_rdata = 32'hCAFE_F00D; tick();
      bus.i_mem_ack = 1'b0;
      chk("late_ack_1", {bus.o_mem_req, bus.o_iack, bus.o_dack}, 3'b000);
      tick();
      chk("late_ack_2", {bus.o_mem_req, bus.o_iack, bus.o_dack, bus.o_irdata}, '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
